// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALU; result returned SETTLE_CYCLES edges after accept.
// Response holds while rsp_ready is low; no new grant is issued until the response handshakes.
module alu_share_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*32-1:0]  req_operand_a,
  input  logic [NUM_REQ*32-1:0]  req_operand_b,
  input  logic [NUM_REQ*3-1:0]   req_command,
  output logic [31:0]            alu_operand_a,
  output logic [31:0]            alu_operand_b,
  output logic [2:0]             alu_command,
  input  logic [31:0]            alu_result,
  input  logic                   alu_carryout,
  input  logic                   alu_zero,
  input  logic                   alu_overflow,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [2:0]             rsp_id,
  output logic [31:0]            rsp_result,
  output logic [2:0]             rsp_flags
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     alu_a_q, alu_a_d;
  logic [31:0]     alu_b_q, alu_b_d;
  logic [2:0]      alu_cmd_q, alu_cmd_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [2:0]      rsp_id_q, rsp_id_d;
  logic [31:0]     rsp_result_q, rsp_result_d;
  logic [2:0]      rsp_flags_q, rsp_flags_d;

  logic            grant_vld;
  logic [PW-1:0]   grant_idx;

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!grant_vld && req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && grant_vld) begin
      req_ready = NUM_REQ'(1) << grant_idx;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_cmd_d    = alu_cmd_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    case (state_q)
      IDLE: begin
        // The granted requester is always valid, so a grant is an accept.
        if (grant_vld) begin
          alu_a_d   = req_operand_a[32*grant_idx +: 32];
          alu_b_d   = req_operand_b[32*grant_idx +: 32];
          alu_cmd_d = req_command[3*grant_idx +: 3];
          rsp_id_d  = 3'(grant_idx);
          ptr_d     = (grant_idx == PW'(NUM_REQ-1)) ? '0 : grant_idx + PW'(1);
          cnt_d     = CW'(SETTLE_CYCLES-1);
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          rsp_result_d = alu_result;
          rsp_flags_d  = {alu_carryout, alu_zero, alu_overflow};
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_cmd_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_cmd_q    <= alu_cmd_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  assign alu_operand_a = alu_a_q;
  assign alu_operand_b = alu_b_q;
  assign alu_command   = alu_cmd_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = rsp_id_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_flags     = rsp_flags_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: transaction model on the default instance plus directed
// checks on SETTLE_CYCLES=1/7 and NUM_REQ=8 instances.
module tb_alu_share_arbiter;

  localparam int S = 4;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU: {result, carryout, zero, overflow}
  function automatic logic [34:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] c);
    logic [32:0] s;
    logic [31:0] r;
    logic cy, z, v;
    s = '0; r = '0; cy = 1'b0; z = 1'b0; v = 1'b0;
    case (c)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0]; cy = s[32]; z = (r == 0);
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0]; cy = s[32]; z = (r == 0);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'd2: r = a ^ b;
      3'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd4: r = a & b;
      3'd5: r = ~(a & b);
      3'd6: r = ~(a | b);
      default: r = a | b;
    endcase
    return {r, cy, z, v};
  endfunction

  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Shared stimulus for the three 4-requester instances
  logic [3:0]   rv;
  logic [127:0] oa, ob;
  logic [11:0]  cmd;
  logic         rdy;

  logic [3:0]  d_rr;
  logic [31:0] d_aa, d_ab, d_res;
  logic [2:0]  d_ac, d_id, d_flg;
  logic        d_v;
  logic [34:0] d_alu;
  assign d_alu = alu_f(d_aa, d_ab, d_ac);

  alu_share_arbiter #(.NUM_REQ(4), .SETTLE_CYCLES(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(rv), .req_ready(d_rr),
    .req_operand_a(oa), .req_operand_b(ob), .req_command(cmd),
    .alu_operand_a(d_aa), .alu_operand_b(d_ab), .alu_command(d_ac),
    .alu_result(d_alu[34:3]), .alu_carryout(d_alu[2]), .alu_zero(d_alu[1]),
    .alu_overflow(d_alu[0]), .rsp_valid(d_v), .rsp_ready(rdy), .rsp_id(d_id),
    .rsp_result(d_res), .rsp_flags(d_flg));

  logic [3:0]  s1_rr;
  logic [31:0] s1_aa, s1_ab, s1_res;
  logic [2:0]  s1_ac, s1_id, s1_flg;
  logic        s1_v;
  logic [34:0] s1_alu;
  assign s1_alu = alu_f(s1_aa, s1_ab, s1_ac);

  alu_share_arbiter #(.NUM_REQ(4), .SETTLE_CYCLES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv), .req_ready(s1_rr),
    .req_operand_a(oa), .req_operand_b(ob), .req_command(cmd),
    .alu_operand_a(s1_aa), .alu_operand_b(s1_ab), .alu_command(s1_ac),
    .alu_result(s1_alu[34:3]), .alu_carryout(s1_alu[2]), .alu_zero(s1_alu[1]),
    .alu_overflow(s1_alu[0]), .rsp_valid(s1_v), .rsp_ready(rdy), .rsp_id(s1_id),
    .rsp_result(s1_res), .rsp_flags(s1_flg));

  logic [3:0]  s7_rr;
  logic [31:0] s7_aa, s7_ab, s7_res;
  logic [2:0]  s7_ac, s7_id, s7_flg;
  logic        s7_v;
  logic [34:0] s7_alu;
  assign s7_alu = alu_f(s7_aa, s7_ab, s7_ac);

  alu_share_arbiter #(.NUM_REQ(4), .SETTLE_CYCLES(7)) u_s7 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv), .req_ready(s7_rr),
    .req_operand_a(oa), .req_operand_b(ob), .req_command(cmd),
    .alu_operand_a(s7_aa), .alu_operand_b(s7_ab), .alu_command(s7_ac),
    .alu_result(s7_alu[34:3]), .alu_carryout(s7_alu[2]), .alu_zero(s7_alu[1]),
    .alu_overflow(s7_alu[0]), .rsp_valid(s7_v), .rsp_ready(rdy), .rsp_id(s7_id),
    .rsp_result(s7_res), .rsp_flags(s7_flg));

  logic [7:0]   n8_rv, n8_rr;
  logic [255:0] n8_oa, n8_ob;
  logic [23:0]  n8_cmd;
  logic         n8_rdy;
  logic [31:0]  n8_aa, n8_ab, n8_res;
  logic [2:0]   n8_ac, n8_id, n8_flg;
  logic         n8_v;
  logic [34:0]  n8_alu;
  assign n8_alu = alu_f(n8_aa, n8_ab, n8_ac);

  alu_share_arbiter #(.NUM_REQ(8), .SETTLE_CYCLES(S)) u_n8 (
    .clk(clk), .rst_n(rst_n), .req_valid(n8_rv), .req_ready(n8_rr),
    .req_operand_a(n8_oa), .req_operand_b(n8_ob), .req_command(n8_cmd),
    .alu_operand_a(n8_aa), .alu_operand_b(n8_ab), .alu_command(n8_ac),
    .alu_result(n8_alu[34:3]), .alu_carryout(n8_alu[2]), .alu_zero(n8_alu[1]),
    .alu_overflow(n8_alu[0]), .rsp_valid(n8_v), .rsp_ready(n8_rdy), .rsp_id(n8_id),
    .rsp_result(n8_res), .rsp_flags(n8_flg));

  // Transaction model of u_dut: one operation in flight, response S edges after accept.
  int          m_ptr, m_age;
  bit          m_busy, m_rv;
  logic [31:0] m_a, m_b, m_res;
  logic [2:0]  m_cmd, m_id, m_flg;

  task automatic model_reset();
    m_ptr = 0; m_age = 0; m_busy = 0; m_rv = 0;
    m_a = '0; m_b = '0; m_res = '0; m_cmd = '0; m_id = '0; m_flg = '0;
  endtask

  initial begin
    int g;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else if (!m_busy) begin
        g = pick(rv, m_ptr);
        if (g >= 0) begin
          m_a = oa[32*g +: 32]; m_b = ob[32*g +: 32]; m_cmd = cmd[3*g +: 3];
          m_id = 3'(g); m_ptr = (g + 1) % 4; m_busy = 1; m_age = 0;
        end
      end else if (!m_rv) begin
        m_age++;
        if (m_age == S) begin
          {m_res, m_flg} = alu_f(m_a, m_b, m_cmd);
          m_rv = 1;
        end
      end else if (rdy) begin
        m_rv = 0; m_busy = 0;
      end
    end
  end

  initial begin
    int g;
    logic [3:0] exp_rr;
    forever begin
      @(negedge clk);
      g = pick(rv, m_ptr);
      exp_rr = (!m_busy && g >= 0) ? (4'd1 << g) : 4'd0;
      chk("req_ready", d_rr, exp_rr);
      chk("alu_operand_a", d_aa, m_a);
      chk("alu_operand_b", d_ab, m_b);
      chk("alu_command", d_ac, m_cmd);
      chk("rsp_valid", d_v, m_rv);
      chk("rsp_id", d_id, m_id);
      chk("rsp_result", d_res, m_res);
      chk("rsp_flags", d_flg, m_flg);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(output int idx, output int e0);
    bit found;
    idx = -1; e0 = 0; found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if ((d_rr & rv) != 0) begin
        found = 1;
        e0 = cyc + 1;
        for (int i = 0; i < 4; i++) if (d_rr[i]) idx = i;
      end
    end
    if (!found) chk("accept_timeout", 32'd1, 32'd0);
    step();
  endtask

  task automatic wait_rsp(output int e);
    bit found;
    e = 0; found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (d_v) begin
        found = 1;
        e = cyc;
      end
    end
    if (!found) chk("rsp_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int idx, e0, e, lat1, lat7;
    int exp_seq[7];
    logic [31:0] r1, r7;
    logic [2:0]  f1, f7;
    bit found;

    exp_seq = '{1, 3, 1, 3, 0, 1, 3};
    rst_n = 1'b1; rv = '0; oa = '0; ob = '0; cmd = '0; rdy = 1'b1;
    n8_rv = '0; n8_oa = '0; n8_ob = '0; n8_cmd = '0; n8_rdy = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_rsp_valid", d_v, 0);
    chk("reset_req_ready", d_rr, 0);
    chk("reset_alu_a", d_aa, 0);
    chk("reset_rsp_id", d_id, 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    step();

    // Single ADD with signed overflow
    oa[31:0] = 32'h7FFF_FFFF; ob[31:0] = 32'h0000_0001; cmd[2:0] = 3'd0; rv = 4'b0001;
    wait_accept(idx, e0);
    rv = '0;
    chk("t1_grant", idx, 0);
    wait_rsp(e);
    chk("t1_latency", e - e0, 4);
    chk("t1_result", d_res, 32'h8000_0000);
    chk("t1_flags", d_flg, 3'b001);
    chk("t1_id", d_id, 0);
    chk("t1_model_result", m_res, 32'h8000_0000);
    chk("t1_model_flags", m_flg, 3'b001);
    step();

    // Round-robin between 1 and 3, then requester 0 joins
    oa[31:0]  = 32'hFFFF_00FF; ob[31:0]  = 32'h0F0F_0F0F; cmd[2:0]  = 3'd4;
    oa[63:32] = 32'hF0F0_0000; ob[63:32] = 32'h0FF0_0000; cmd[5:3]  = 3'd2;
    oa[127:96] = 32'h1234_0000; ob[127:96] = 32'h0000_5678; cmd[11:9] = 3'd6;
    rv = 4'b1010;
    for (int k = 0; k < 7; k++) begin
      if (k == 4) rv = 4'b1011;
      wait_accept(idx, e0);
      chk("t2_grant", idx, exp_seq[k]);
    end
    rv = '0;
    wait_rsp(e);
    step();

    // SUB under backpressure
    oa[95:64] = 32'd5; ob[95:64] = 32'd5; cmd[8:6] = 3'd1;
    rdy = 1'b0; rv = 4'b0100;
    wait_accept(idx, e0);
    rv = '0;
    chk("t3_grant", idx, 2);
    wait_rsp(e);
    chk("t3_latency", e - e0, 4);
    for (int k = 0; k < 10; k++) begin
      step();
      rv = 4'hF;
      @(negedge clk);
      chk("t3_hold_valid", d_v, 1);
      chk("t3_hold_result", d_res, 0);
      chk("t3_hold_flags", d_flg, 3'b110);
      chk("t3_hold_ready", d_rr, 0);
    end
    step();
    rdy = 1'b1;
    @(negedge clk);
    chk("t3_before_edge_valid", d_v, 1);
    step();
    @(negedge clk);
    chk("t3_idle_valid", d_v, 0);
    chk("t3_idle_ready", d_rr, 4'b1000);
    chk("t3_retain_result", d_res, 0);
    chk("t3_retain_flags", d_flg, 3'b110);
    chk("t3_retain_id", d_id, 2);
    step();
    rv = '0;
    wait_rsp(e);
    step();

    // Reset while in SETTLE
    oa[95:64] = 32'h1234_5678; ob[95:64] = 32'd1; cmd[8:6] = 3'd0; rv = 4'b0100;
    wait_accept(idx, e0);
    rv = '0;
    step(); step();
    #3 rst_n = 1'b0;
    #1;
    chk("t4_rst_valid", d_v, 0);
    chk("t4_rst_ready", d_rr, 0);
    chk("t4_rst_alu_a", d_aa, 0);
    chk("t4_rst_alu_b", d_ab, 0);
    chk("t4_rst_alu_cmd", d_ac, 0);
    chk("t4_rst_id", d_id, 0);
    chk("t4_rst_result", d_res, 0);
    chk("t4_rst_flags", d_flg, 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t4_no_rsp", d_v, 0);
    end

    // First grant after reset, and SLT through SETTLE_CYCLES=1 and 7
    step();
    oa[31:0] = 32'hFFFF_FFFF; ob[31:0] = 32'd1; cmd[2:0] = 3'd3; rv = 4'hF;
    @(negedge clk);
    chk("t5_first_grant", d_rr, 4'b0001);
    chk("t5_s1_grant", s1_rr, 4'b0001);
    chk("t5_s7_grant", s7_rr, 4'b0001);
    e0 = cyc + 1;
    step();
    rv = '0;
    lat1 = -1; lat7 = -1; r1 = '0; r7 = '0; f1 = '1; f7 = '1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (s1_v && lat1 < 0) begin lat1 = cyc - e0; r1 = s1_res; f1 = s1_flg; end
      if (s7_v && lat7 < 0) begin lat7 = cyc - e0; r7 = s7_res; f7 = s7_flg; end
    end
    chk("t5_s1_latency", lat1, 1);
    chk("t5_s1_result", r1, 1);
    chk("t5_s1_flags", f1, 0);
    chk("t5_s7_latency", lat7, 7);
    chk("t5_s7_result", r7, 1);
    chk("t5_s7_flags", f7, 0);
    step();

    // NUM_REQ=8 wrap-around over 9 transactions
    for (int i = 0; i < 8; i++) begin
      n8_oa[32*i +: 32] = 32'(i * 3);
      n8_ob[32*i +: 32] = 32'd1;
      n8_cmd[3*i +: 3]  = 3'd0;
    end
    n8_rv = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      found = 0;
      for (int t = 0; t < 20 && !found; t++) begin
        @(negedge clk);
        if (n8_v) found = 1;
      end
      if (!found) chk("t6_rsp_timeout", 32'd1, 32'd0);
      chk("t6_id", n8_id, k % 8);
      chk("t6_result", n8_res, (k % 8) * 3 + 1);
      @(posedge clk);
    end
    @(negedge clk);
    chk("t6_ptr_after_wrap", n8_rr, 8'b0000_0010);
    step();
    n8_rv = '0;

    repeat (5) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
